// File: rtl/pulse_level_gen.sv
// Turns single-cycle request events into fixed-width level pulses separated by a guaranteed low gap.
// Requests that arrive while a pulse is in progress wait in a saturating pending counter.
module pulse_level_gen #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    output logic             level_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int MAX_PH = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

    localparam logic [PH_W-1:0]  HIGH_LAST = PH_W'(HIGH_CYCLES - 1);
    localparam logic [PH_W-1:0]  LOW_LAST  = PH_W'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PH_W-1:0]  r_phase;
    logic [PH_W-1:0]  w_phase_next;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] w_pending_next;
    logic             r_level;
    logic             r_busy;
    logic             r_overflow;
    logic             w_have_req;
    logic             w_start;
    logic             w_drop;

    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    always_comb begin
        w_have_req   = pulse_in | (r_pending != '0);
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_start      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_have_req) begin
                    w_start      = 1'b1;
                    w_state_next = S_HIGH;
                    w_phase_next = '0;
                end
            end
            S_HIGH: begin
                if (r_phase == HIGH_LAST) begin
                    w_state_next = S_LOW;
                    w_phase_next = '0;
                end else begin
                    w_phase_next = r_phase + PH_W'(1);
                end
            end
            S_LOW: begin
                if (r_phase == LOW_LAST) begin
                    w_phase_next = '0;
                    if (w_have_req) begin
                        w_start      = 1'b1;
                        w_state_next = S_HIGH;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_phase_next = r_phase + PH_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_phase_next = '0;
            end
        endcase

        // A start in the same cycle absorbs the incoming request, so only a stalled full counter drops one.
        w_drop = pulse_in & ~w_start & (r_pending == PEND_MAX);

        case ({pulse_in & ~w_drop, w_start})
            2'b10:   w_pending_next = r_pending + CNT_W'(1);
            2'b01:   w_pending_next = r_pending - CNT_W'(1);
            default: w_pending_next = r_pending;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_pending  <= '0;
            r_level    <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_phase    <= w_phase_next;
            r_pending  <= w_pending_next;
            r_level    <= (w_state_next == S_HIGH);
            r_busy     <= (w_state_next != S_IDLE);
            r_overflow <= w_drop;
        end
    end

    assign level_out = r_level;
    assign busy      = r_busy;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_pulse_level_gen.sv
// Self-checking bench for pulse_level_gen: directed scenarios plus random traffic,
// compared every cycle against a timeline model built from start times and a pending count.
module tb_pulse_level_gen;

    localparam int H    = 4;
    localparam int L    = 2;
    localparam int CW   = 2;
    localparam int PMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pulse_in = 1'b0;
    logic          level_out;
    logic          busy;
    logic [CW-1:0] pending;
    logic          overflow;

    pulse_level_gen #(
        .HIGH_CYCLES(H),
        .LOW_CYCLES (L),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .level_out(level_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a pulse started in cycle s is high in s+1..s+H and busy in s+1..s+H+L;
    // the next start is allowed from cycle s+H+L onwards.
    int cyc        = 0;
    int last_start = -1000;
    int m_pend     = 0;
    bit m_ovf      = 1'b0;

    // Observations of the DUT, cleared per scenario.
    int edges    = 0;
    int hi_cnt   = 0;
    int ovf_cnt  = 0;
    int low_run  = 1000;
    bit prev_lvl = 1'b0;
    bit gap_chk  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        edges   = 0;
        hi_cnt  = 0;
        ovf_cnt = 0;
    endtask

    task automatic step(input bit p, input bit r);
        bit can_start;
        bit st;
        int d;
        @(negedge clk);
        pulse_in = p;
        reset    = r;
        @(posedge clk);
        if (r) begin
            last_start = -1000;
            m_pend     = 0;
            m_ovf      = 1'b0;
        end else begin
            can_start = (cyc >= last_start + H + L);
            st        = can_start && (p || m_pend > 0);
            m_ovf     = p && !st && (m_pend == PMAX);
            if (st) last_start = cyc;
            if (!m_ovf) m_pend = m_pend + int'(p) - int'(st);
        end
        d = cyc + 1 - last_start;
        #1;
        check("level_out", {31'd0, level_out}, {31'd0, (d >= 1 && d <= H)});
        check("busy", {31'd0, busy}, {31'd0, (d >= 1 && d <= H + L)});
        check("pending", {{(32-CW){1'b0}}, pending}, m_pend);
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (level_out === 1'b1) hi_cnt++;
        if (overflow === 1'b1) ovf_cnt++;
        if (level_out === 1'b1 && !prev_lvl) begin
            edges++;
            if (gap_chk) check("low_gap", {31'd0, (low_run >= L)}, 32'd1);
        end
        low_run  = (level_out === 1'b1) ? 0 : low_run + 1;
        prev_lvl = (level_out === 1'b1);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        // Reset held with pulse_in toggling, then first cycle after release.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        idle(5);

        // Single request.
        clear_obs();
        step(1'b1, 1'b0);
        idle(10);
        check("single_edges", edges, 1);
        check("single_high_cycles", hi_cnt, H);

        // Three back-to-back requests.
        clear_obs();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        idle(20);
        check("b2b_edges", edges, 3);
        check("b2b_high_cycles", hi_cnt, 3 * H);

        // Five consecutive requests saturate the 2-bit counter; the fifth is dropped.
        clear_obs();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        idle(30);
        check("ovf_edges", edges, 4);
        check("ovf_flags", ovf_cnt, 1);

        // Reset during the high phase with two requests queued.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        clear_obs();
        idle(20);
        check("post_reset_edges", edges, 0);

        // Loopback: seven spaced requests through a rising-edge detector.
        clear_obs();
        gap_chk = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b0);
            idle($urandom_range(4, 10));
        end
        idle(40);
        gap_chk = 1'b0;
        check("loop_edges", edges, 7);
        check("loop_overflow", ovf_cnt, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0);
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
